// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor: a single 1-bit full-subtractor cell
// is time-multiplexed LSB first over WIDTH cycles behind a start/done handshake.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic             load;
    logic             shift;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             borrow_ff;
    logic [CNT_W-1:0] cnt;
    logic             cell_diff;
    logic             cell_bout;

    // Full-subtractor cell: returns {bout, diff} for x - y - bin.
    function automatic logic [1:0] full_subtractor(input logic x, input logic y,
                                                   input logic bin);
        logic d;
        logic bo;
        d  = x ^ y ^ bin;
        bo = (~x & y) | (~(x ^ y) & bin);
        return {bo, d};
    endfunction

    assign {cell_bout, cell_diff} = full_subtractor(a_sh[0], b_sh[0], borrow_ff);
    assign res_next = {cell_diff, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == CNT_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        last  = 1'b0;
        case (state)
            IDLE: load = start;
            RUN: begin
                shift = 1'b1;
                last  = (cnt == CNT_LAST);
            end
            default: ;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state == RUN);
            done <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            a_sh      <= a;
            b_sh      <= b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
        end else if (shift) begin
            a_sh      <= a_sh >> 1;
            b_sh      <= b_sh >> 1;
            res_sh    <= res_next;
            borrow_ff <= cell_bout;
            cnt       <= cnt + CNT_W'(1);
        end
    end

    // Result holds the previous value until the last bit lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (last) begin
            diff       <= res_next;
            borrow_out <= cell_bout;
        end
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial multi-bit subtractor. One instance of the team's 1-bit Full_Subtractor cell (ports a, b, bin, diff, bout) computes a WIDTH-bit unsigned difference, LSB first, over WIDTH cycles. The controller owns the operand and result shift registers, the borrow flip-flop and a start/done handshake. It lets the existing full-subtractor cell serve as a multi-bit arithmetic unit without replicating it.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when the result is valid
diff  output  WIDTH  registered (a - b) mod 2^WIDTH
borrow_out  output  1  registered final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; shift registers, borrow FF and counter cleared. A reset during RUN abandons the operation; no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at a rising edge (edge k):
  - a_sh<=a, b_sh<=b, borrow FF<=0, cnt<=0.
  - Go to RUN.
- Otherwise stay in IDLE.
- RUN: the cell inputs are a_sh[0], b_sh[0] and the borrow FF. At each edge:
  - The cell diff output shifts into the MSB of res_sh, and res_sh shifts right.
  - borrow FF<=cell bout.
  - a_sh and b_sh shift right.
  - cnt<=cnt+1.
- When cnt=WIDTH-1 at an edge (the last bit):
  - Go to DONE.
  - diff<=final res_sh value, including the bit shifted in this cycle.
  - borrow_out<=bout.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Latency: start accepted at edge k; RUN covers edges k+1..k+WIDTH; done is high in the cycle after edge k+WIDTH.
- A new start can be accepted in the IDLE cycle after DONE, giving a throughput of one operation per WIDTH+2 cycles.
- busy=1 exactly while state=RUN. done and busy are never high together.
- start is ignored in RUN and DONE. No queueing, and no error flag.
- Changes on a or b after the accepting edge have no effect on the running operation.
- diff and borrow_out hold the last completed result until the next completion; they do not change during RUN.
- Counter width is $clog2(WIDTH). cnt never exceeds WIDTH-1.
- Arithmetic: unsigned two's-complement wrap.
  - diff = (a + 2^WIDTH - b) mod 2^WIDTH.
  - borrow_out = borrow out of the MSB.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, single start pulse -> busy high for 8 cycles; done pulse on cycle 9 after the accepting edge; diff=0x37, borrow_out=0.
- a=0x23, b=0x5A -> diff=0xC9, borrow_out=1. Edge cases: a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
- Hold start=1 continuously with a=0x10, b=0x01, changing a/b every cycle during RUN -> first result diff=0x0F, borrow_out=0. Mid-run changes and start have no effect. The next operation is accepted in the IDLE cycle after DONE, using the a/b present at that edge.
- Drop rst_n=0 at RUN cycle 4 of a=0x80, b=0x01 -> all outputs 0 immediately (asynchronous); no done pulse. After release, a fresh start with a=0x80, b=0x01 -> diff=0x7F, borrow_out=0.
- Between operations, check that diff/borrow_out keep the previous result (0x37/0) throughout the next RUN until its done.
- Self-check sweep: random 200 operand pairs, WIDTH=8 and WIDTH=4 -> diff and borrow_out match the reference model {borrow, diff} = {1'b0, a} - {1'b0, b} on every done.
